// File: rtl/mips_seq_pkg.sv
// Shared state encoding and sizing helpers for the multi-cycle MIPS sequencer.
// Latency: none (types, constants and a width helper only).
// Backpressure: none.
package mips_seq_pkg;

  // The debug port exposes these codes directly, so keep the values fixed.
  typedef enum logic [3:0] {
    RST    = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    EXEC   = 4'd3,
    MEM    = 4'd4,
    WB     = 4'd5,
    HALT   = 4'd6,
    ERROR  = 4'd7
  } seq_state_t;

  localparam int DEFAULT_MEM_TIMEOUT = 255;

  // Wide enough to hold the timeout value itself, because the limit is reached
  // only after exactly that many wait cycles.
  function automatic int wait_cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

  localparam int WAIT_CNT_W = wait_cnt_width(DEFAULT_MEM_TIMEOUT);

endpackage

// File: rtl/seq_wait_timer.sv
// Wait-cycle counter shared by the instruction fetch, data memory and mult/div waits.
// Latency: expired reflects the count registered at the previous edge (no combinational path from waiting).
// Backpressure: none; counts only while the owner holds a request with ready low.
module seq_wait_timer
  import mips_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int CNT_W       = wait_cnt_width(MEM_TIMEOUT)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] cnt;

  // Count unanswered request cycles; restart whenever the sequencer changes state.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (waiting && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // The owner still lets a same-cycle ready win over this flag.
  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/mips_cycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer between the decoder and the datapath.
// Latency: 4 cycles for ALU ops with zero-wait memory, plus one cycle per memory wait.
// Backpressure: holds FETCH/MEM (and EXEC with SEQ_MULDIV_WAIT_EN defined) until ready; MEM_TIMEOUT waits gives ERROR.
module mips_cycle_sequencer
  import mips_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dec_mem_read,
  input  logic                dec_mem_write,
  input  logic                dec_reg_write,
  input  logic                dec_syscall,
  input  logic                dec_muldiv,
  input  logic                alu_done,
  input  logic                inst_ready,
  input  logic                data_ready,
  output logic                inst_read_en,
  output logic                ir_write,
  output logic                mem_read_en,
  output logic                mem_write_en,
  output logic                reg_write_en,
  output logic                pc_write,
  output logic                alu_start,
  output logic                halted,
  output logic                error,
  output logic [RETIRE_W-1:0] retired,
  output logic [3:0]          state_dbg
);

  seq_state_t state;
  seq_state_t state_nxt;

  logic wait_clr;
  logic waiting;
  logic expired;
  logic exec_go;

`ifdef SEQ_MULDIV_WAIT_EN
  // Set once the start pulse has gone out, so the pulse is issued only once per EXEC visit.
  logic md_started;
`else
  logic unused_muldiv;
  assign unused_muldiv = &{1'b0, dec_muldiv, alu_done};
`endif

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RST;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef SEQ_MULDIV_WAIT_EN
  // Track whether the mult/div start pulse has been issued during this EXEC visit.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_started <= 1'b0;
    end else begin
      md_started <= (state == EXEC) && (state_nxt == EXEC);
    end
  end
`endif

  // Next-state and output decode; ir_write and pc_write on ready paths are Mealy.
  always_comb begin
    state_nxt    = state;
    inst_read_en = 1'b0;
    ir_write     = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    reg_write_en = 1'b0;
    pc_write     = 1'b0;
    alu_start    = 1'b0;
    halted       = 1'b0;
    error        = 1'b0;
    waiting      = 1'b0;
    exec_go      = 1'b1;

    case (state)
      RST: begin
        state_nxt = FETCH;
      end

      FETCH: begin
        inst_read_en = 1'b1;
        if (inst_ready) begin
          ir_write  = 1'b1;
          state_nxt = DECODE;
        end else if (expired) begin
          state_nxt = ERROR;
        end else begin
          waiting = 1'b1;
        end
      end

      DECODE: begin
        if (dec_syscall) begin
          state_nxt = HALT;
        end else if (dec_mem_read && dec_mem_write) begin
          state_nxt = ERROR;
        end else begin
          state_nxt = EXEC;
        end
      end

      EXEC: begin
`ifdef SEQ_MULDIV_WAIT_EN
        if (dec_muldiv) begin
          if (!md_started) begin
            alu_start = 1'b1;
            exec_go   = 1'b0;
          end else if (!alu_done) begin
            exec_go = 1'b0;
            if (expired) begin
              state_nxt = ERROR;
            end else begin
              waiting = 1'b1;
            end
          end
        end
`endif
        if (exec_go) begin
          if (dec_mem_read || dec_mem_write) begin
            state_nxt = MEM;
          end else if (dec_reg_write) begin
            state_nxt = WB;
          end else begin
            // Branches, jumps and nops retire straight out of EXEC.
            pc_write  = 1'b1;
            state_nxt = FETCH;
          end
        end
      end

      MEM: begin
        mem_read_en  = dec_mem_read;
        mem_write_en = dec_mem_write;
        if (data_ready) begin
          if (dec_mem_write) begin
            pc_write  = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = WB;
          end
        end else if (expired) begin
          state_nxt = ERROR;
        end else begin
          waiting = 1'b1;
        end
      end

      WB: begin
        reg_write_en = 1'b1;
        pc_write     = 1'b1;
        state_nxt    = FETCH;
      end

      HALT: begin
        halted = 1'b1;
      end

      ERROR: begin
        error = 1'b1;
      end

      default: begin
        state_nxt = ERROR;
      end
    endcase

    // Nothing may leave the block on a reset edge, even mid-instruction.
    if (reset) begin
      state_nxt    = RST;
      inst_read_en = 1'b0;
      ir_write     = 1'b0;
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
      reg_write_en = 1'b0;
      pc_write     = 1'b0;
      alu_start    = 1'b0;
      halted       = 1'b0;
      error        = 1'b0;
      waiting      = 1'b0;
    end
  end

  // Every instruction that completes issues exactly one pc_write, so count those.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired <= '0;
    end else if (pc_write) begin
      retired <= retired + RETIRE_W'(1);
    end
  end

  // Any state change starts a fresh wait budget for the next request.
  assign wait_clr  = (state_nxt != state);
  assign state_dbg = state;

  seq_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (wait_clr),
    .waiting(waiting),
    .expired(expired)
  );

endmodule

// File: tb/tb_mips_cycle_sequencer.sv
// Randomized scoreboard bench for the multi-cycle sequencer.
// Latency: n/a.
// Backpressure: the bench plays instruction/data memory with per-instruction wait counts.
module tb_mips_cycle_sequencer;

  localparam int T  = 4;   // timeout used for this build of the DUT
  localparam int RW = 4;   // small retire counter so wrap-around is reachable

  localparam int K_RET   = 0;
  localparam int K_HALT  = 1;
  localparam int K_ERR   = 2;
  localparam int K_ABORT = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          dec_mem_read = 1'b0;
  logic          dec_mem_write = 1'b0;
  logic          dec_reg_write = 1'b0;
  logic          dec_syscall = 1'b0;
  logic          dec_muldiv = 1'b0;
  logic          alu_done = 1'b0;
  logic          inst_ready = 1'b0;
  logic          data_ready = 1'b0;
  logic          inst_read_en;
  logic          ir_write;
  logic          mem_read_en;
  logic          mem_write_en;
  logic          reg_write_en;
  logic          pc_write;
  logic          alu_start;
  logic          halted;
  logic          error;
  logic [RW-1:0] retired;
  logic [3:0]    state_dbg;

  mips_cycle_sequencer #(
    .MEM_TIMEOUT(T),
    .RETIRE_W   (RW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dec_mem_read (dec_mem_read),
    .dec_mem_write(dec_mem_write),
    .dec_reg_write(dec_reg_write),
    .dec_syscall  (dec_syscall),
    .dec_muldiv   (dec_muldiv),
    .alu_done     (alu_done),
    .inst_ready   (inst_ready),
    .data_ready   (data_ready),
    .inst_read_en (inst_read_en),
    .ir_write     (ir_write),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .reg_write_en (reg_write_en),
    .pc_write     (pc_write),
    .alu_start    (alu_start),
    .halted       (halted),
    .error        (error),
    .retired      (retired),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  // One instruction: decode bits, fetch wait, data wait, and an optional
  // reset injected after 'abort' data-memory wait cycles (-1 = none).
  typedef struct {
    bit rd;
    bit wr;
    bit rg;
    bit sys;
    int iw;
    int dw;
    int abort;
  } item_t;

  // What one instruction should look like from the outside.
  typedef struct {
    int kind;
    int cycles;
    int irw;
    int memc;
    int regw;
    int pcw;
    int alu;
    int ret_before;
    int gap;
  } rec_t;

  rec_t expq[$];
  rec_t obs;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   active = 1'b0;
  int   since_reset = 1000;
  int   model_ret = 0;
  bit   first = 1'b1;
  logic [6:0] strobes;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic item_t mk(input bit rd, input bit wr, input bit rg, input bit sys,
                               input int iw, input int dw, input int abort);
    item_t it;
    it.rd = rd; it.wr = wr; it.rg = rg; it.sys = sys;
    it.iw = iw; it.dw = dw; it.abort = abort;
    return it;
  endfunction

  // Reference: cycle counts and strobe totals straight from the instruction rules.
  function automatic rec_t model(input item_t it, input int ret, input bit is_first);
    rec_t e;
    int   f;
    e.kind = K_RET; e.cycles = 0; e.irw = 0; e.memc = 0; e.regw = 0;
    e.pcw = 0; e.alu = 0; e.ret_before = ret; e.gap = is_first ? 1 : -1;
    if (it.iw > T) begin
      e.kind = K_ERR;
      e.cycles = T + 1;
      return e;
    end
    f = it.iw + 1;
    e.irw = 1;
    if (it.sys) begin
      e.kind = K_HALT;
      e.cycles = f + 1;
    end else if (it.rd && it.wr) begin
      e.kind = K_ERR;
      e.cycles = f + 1;
    end else if (it.rd || it.wr) begin
      if (it.abort >= 0) begin
        e.kind = K_ABORT;
        e.cycles = f + 2 + it.abort;
        e.memc = it.abort;
      end else if (it.dw > T) begin
        e.kind = K_ERR;
        e.cycles = f + 2 + T + 1;
        e.memc = T + 1;
      end else begin
        e.memc = it.dw + 1;
        e.pcw = 1;
        e.regw = it.rd ? 1 : 0;
        e.cycles = f + 2 + it.dw + 1 + (it.rd ? 1 : 0);
      end
    end else begin
      e.pcw = 1;
      e.regw = it.rg ? 1 : 0;
      e.cycles = f + 2 + (it.rg ? 1 : 0);
    end
    return e;
  endfunction

  task automatic close_rec(input int kind);
    rec_t e;
    if (expq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_completion: got kind %0d, expected nothing queued", kind);
      return;
    end
    e = expq.pop_front();
    chk("outcome", kind, e.kind);
    chk("cycles", obs.cycles, e.cycles);
    chk("ir_write_count", obs.irw, e.irw);
    chk("mem_en_cycles", obs.memc, e.memc);
    chk("reg_write_count", obs.regw, e.regw);
    chk("pc_write_count", obs.pcw, e.pcw);
    chk("alu_start_count", obs.alu, e.alu);
    chk("retired_before", obs.ret_before, e.ret_before);
    if (e.gap >= 0) chk("fetch_after_reset", obs.gap, e.gap);
    if (kind == K_HALT) chk("state_dbg_halt", int'(state_dbg), 6);
    if (kind == K_ERR) chk("state_dbg_error", int'(state_dbg), 7);
  endtask

  // Monitor: watches the DUT each cycle and closes an instruction on its terminal event.
  always @(negedge clk) begin
    strobes = {inst_read_en, ir_write, mem_read_en, mem_write_en, reg_write_en, pc_write, alu_start};
    if (reset) begin
      chk("reset_outputs_quiet", int'({strobes, halted, error}), 0);
      if (active) begin
        active = 1'b0;
        close_rec(K_ABORT);
      end
      since_reset = 0;
    end else begin
      if (since_reset == 0) begin
        chk("rst_state_dbg", int'(state_dbg), 0);
        chk("rst_retired", int'(retired), 0);
        chk("rst_outputs", int'({strobes, halted, error}), 0);
      end
      if (!active && inst_read_en) begin
        active = 1'b1;
        obs.kind = K_RET; obs.cycles = 0; obs.irw = 0; obs.memc = 0; obs.regw = 0;
        obs.pcw = 0; obs.alu = 0; obs.ret_before = int'(retired); obs.gap = since_reset;
      end
      if (active) begin
        if (halted) begin
          active = 1'b0;
          close_rec(K_HALT);
        end else if (error) begin
          active = 1'b0;
          close_rec(K_ERR);
        end else begin
          obs.cycles++;
          obs.irw  += int'(ir_write);
          obs.memc += int'(mem_read_en || mem_write_en);
          obs.regw += int'(reg_write_en);
          obs.pcw  += int'(pc_write);
          obs.alu  += int'(alu_start);
          if (pc_write) begin
            active = 1'b0;
            close_rec(K_RET);
          end
        end
      end else if (halted || error) begin
        chk("parked_outputs_quiet", int'(strobes), 0);
      end
      since_reset++;
    end
  end

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (!inst_read_en && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!inst_read_en) begin
      n_cmp++;
      n_bad++;
      $display("FAIL fetch_wait: got no inst_read_en within %0d cycles, expected a fetch", n);
      pulse_reset();
      model_ret = 0;
      first = 1'b1;
    end
  endtask

  // Driver: presents decode bits and acts as both memories for one instruction.
  task automatic run_item(input item_t it);
    rec_t e;
    int   k = 0;
    int   m = 0;
    int   cyc = 0;
    bit   was_f, was_m, was_pc;
    bit   aborted = 1'b0;
    dec_mem_read  = it.rd;
    dec_mem_write = it.wr;
    dec_reg_write = it.rg;
    dec_syscall   = it.sys;
    dec_muldiv    = 1'($urandom);
    e = model(it, model_ret, first);
    expq.push_back(e);
    first = 1'b0;
    while (1) begin
      inst_ready = inst_read_en && (k == it.iw);
      data_ready = (mem_read_en || mem_write_en) && (m == it.dw);
      alu_done   = 1'($urandom);
      if (it.abort >= 0 && (mem_read_en || mem_write_en) && m == it.abort) reset = 1'b1;
      #1;
      was_f  = inst_read_en;
      was_m  = mem_read_en || mem_write_en;
      was_pc = pc_write;
      @(posedge clk); #1;
      if (reset) begin
        reset = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (was_f) k++;
      if (was_m) m++;
      cyc++;
      if (was_pc || halted || error) break;
      if (cyc > 60) begin
        n_cmp++;
        n_bad++;
        $display("FAIL item_timeout: got %0d cycles without completion, expected at most 60", cyc);
        break;
      end
    end
    inst_ready = 1'b0;
    data_ready = 1'b0;
    if (e.kind == K_RET) model_ret = (model_ret + 1) % (1 << RW);
    if (aborted || halted || error || e.kind != K_RET) begin
      if (!aborted) begin
        repeat (2) begin @(posedge clk); #1; end
        pulse_reset();
      end
      model_ret = 0;
      first = 1'b1;
    end
    wait_fetch();
  endtask

  initial begin
    item_t it;
    int    n;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_fetch();

    // Directed: back-to-back ALU ops, load with waits, zero-wait store.
    repeat (3) run_item(mk(0, 0, 1, 0, 0, 0, -1));
    run_item(mk(1, 0, 1, 0, 0, 2, -1));
    run_item(mk(0, 1, 0, 0, 0, 0, -1));
    run_item(mk(0, 0, 0, 0, 0, 0, -1));
    // Ready on the very cycle the timeout is reached wins; one cycle later errors.
    run_item(mk(0, 0, 1, 0, T, 0, -1));
    run_item(mk(1, 0, 1, 0, 1, T, -1));
    run_item(mk(0, 0, 1, 0, T + 1, 0, -1));
    run_item(mk(0, 1, 0, 0, 0, T + 1, -1));
    // Syscall after two ALU ops, then illegal load+store decode.
    run_item(mk(0, 0, 1, 0, 0, 0, -1));
    run_item(mk(0, 0, 1, 0, 0, 0, -1));
    run_item(mk(0, 0, 0, 1, 0, 0, -1));
    run_item(mk(1, 1, 0, 0, 0, 0, -1));
    // Reset in the middle of a load's data wait.
    run_item(mk(1, 0, 1, 0, 0, 20, 2));
    // Long run of retirements to wrap the counter.
    repeat (18) run_item(mk(0, 0, 1, 0, 0, 0, -1));

    for (int i = 0; i < 200; i++) begin
      it.rd    = ($urandom % 3) == 0;
      it.wr    = ($urandom % 3) == 0;
      it.rg    = 1'($urandom);
      it.sys   = ($urandom % 16) == 0;
      it.iw    = ($urandom_range(0, 9) < 9) ? $urandom_range(0, 3) : $urandom_range(4, 5);
      it.dw    = ($urandom_range(0, 9) < 9) ? $urandom_range(0, 3) : $urandom_range(4, 5);
      it.abort = (it.rd != it.wr && !it.sys && ($urandom % 20) == 0) ? 0 : -1;
      if (it.abort == 0) begin
        it.abort = $urandom_range(0, 3);
        it.dw    = 10;
      end
      run_item(it);
    end

    n = 0;
    while (expq.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_cycle_sequencer.md
Name: mips_cycle_sequencer

Overview:
Multi-cycle sequencer placed between the combinational instruction decoder and the datapath. It turns each decoded instruction into a FETCH / DECODE / EXECUTE / MEM / WRITEBACK sequence and waits on instruction and data memory ready handshakes. It issues single-cycle PC, IR and register-file write strobes, halts on syscall, and flags memory timeouts.

Parameters:
MEM_TIMEOUT, 255, max wait cycles for any memory ready before entering ERROR; legal range 1..65535.
RETIRE_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high.
dec_mem_read  in  1  decoded load.
dec_mem_write  in  1  decoded store.
dec_reg_write  in  1  decoded register write.
dec_syscall  in  1  decoded syscall.
dec_muldiv  in  1  decoded MULT/DIV; ignored unless the optional feature is compiled in.
alu_done  in  1  iterative mult/div finished; ignored unless the optional feature is compiled in.
inst_ready  in  1  instruction memory data valid.
data_ready  in  1  data memory access complete.
inst_read_en  out  1  instruction fetch request.
ir_write  out  1  latch the instruction register.
mem_read_en  out  1  data memory read request.
mem_write_en  out  1  data memory write request.
reg_write_en  out  1  register file write strobe.
pc_write  out  1  PC update strobe; the datapath picks next PC.
alu_start  out  1  one-cycle mult/div start pulse.
halted  out  1  sticky; set by syscall.
error  out  1  sticky; set by timeout or illegal decode.
retired  out  RETIRE_W  count of completed instructions.
state_dbg  out  4  current state encoding.

Behaviour:
- States: RST, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR.
- All outputs are Moore functions of state, except ir_write and pc_write on the memory-ready paths, which are Mealy and gated by ready.
- Reset (edge with reset=1):
  - state moves to RST; every output is 0; retired=0; timeout counter=0.
  - Reset in any state, including mid-wait, aborts the instruction; no strobe is issued on the reset edge.
  - RST goes to FETCH on the next cycle.
- FETCH:
  - inst_read_en=1.
  - If inst_ready=1 in the same cycle: ir_write=1 for that cycle, then go to DECODE (zero-wait is legal).
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE (1 cycle):
  - dec_syscall=1: go to HALT.
  - dec_mem_read and dec_mem_write both 1: go to ERROR.
  - Otherwise go to EXEC.
- EXEC (1 cycle):
  - dec_mem_read or dec_mem_write: go to MEM.
  - else dec_reg_write: go to WB.
  - else (branch, jump, JR, nop): pc_write=1, retired+=1, go to FETCH.
- MEM:
  - Assert mem_read_en or mem_write_en, held until data_ready.
  - On data_ready, a store gives pc_write=1, retired+=1, then FETCH.
  - On data_ready, a load goes to WB.
- WB (1 cycle): reg_write_en=1, pc_write=1, retired+=1, then FETCH.
- HALT: halted=1; all enables and strobes 0; stays until reset.
- ERROR: error=1; all enables and strobes 0; stays until reset.
- Decode inputs are sampled each cycle; the datapath holds them stable from IR latch until the next FETCH.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM.
  - It increments each cycle a request is held with ready=0.
  - When the counter equals MEM_TIMEOUT and ready=0, go to ERROR.
  - Ready arriving in that same cycle wins; no error.
- retired wraps modulo 2^RETIRE_W and is never saturated.
- pc_write and reg_write_en are never high for more than one cycle per instruction.

Optional Feature:
- Macro SEQ_MULDIV_WAIT_EN.
- Defined:
  - EXEC with dec_muldiv=1 pulses alu_start for 1 cycle, then holds in EXEC until alu_done=1.
  - Then it proceeds per the EXEC rules.
  - The alu_done wait uses the same timeout counter and MEM_TIMEOUT.
- Undefined:
  - alu_start is tied to 0; dec_muldiv and alu_done are ignored.
  - EXEC is always one cycle.

Decomposition:
- Package mips_seq_pkg:
  - seq_state_t enum with the 4-bit encodings RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERROR=7.
  - localparam for the counter width, $clog2(MEM_TIMEOUT+1).
- Sub-module seq_wait_timer holds the clear / increment / expired counter, shared by the FETCH, MEM and EXEC waits.

Test Plan:
- ADD, zero-wait memory (inst_ready=1 always): cycles are FETCH(ir_write), DECODE, EXEC, WB(reg_write_en, pc_write); repeat is 4 cycles per instruction; retired=3 after 12 cycles.
- LW, inst_ready=1, data_ready after 2 wait cycles: mem_read_en high for 3 cycles, then WB; 7 cycles total; reg_write_en pulses once.
- SW, zero-wait: mem_write_en for 1 cycle and pc_write in the same cycle; reg_write_en never asserted; 4 cycles total.
- MEM_TIMEOUT=4, inst_ready=0: ERROR after 4 wait cycles with error=1; then inst_ready=1 on the 4th wait cycle of a new run (post-reset) gives no error and goes to DECODE.
- Syscall after 2 ADDs: halted=1, retired=2, no further inst_read_en; reset=1 for 1 cycle clears halted, and FETCH resumes 2 cycles later.
- Reset asserted mid-MEM wait of an LW: no reg_write_en or pc_write; retired=0; FETCH after RST; with SEQ_MULDIV_WAIT_EN, MULT and alu_done after 5 cycles gives alu_start once and EXEC held for 6 cycles.
